fp_mul_arbiter: RTL and testbench

//  Shares one combinational FP32 multiplier (fp_mul datapath) among NREQ requesters.
//  - Round-robin arbitration over valid/ready request ports.
//  - Registers operands and sequences the multiply.
//  - Returns result, exception flags and requester id on one valid/ready response channel.
//  - Sits between the FPU issue logic and the multiplier instance.

---
 rtl/fp_mul_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/fp_mul_arbiter.sv | 140 ++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_mul_pkg
// Brief   : Shared types and constants for the FP32 multiplier front end.
// Revision: 1.0
// ============================================================================
package fp_mul_pkg;

    typedef struct packed {
        logic ovrf;
        logic udrf;
        logic zer;
        logic inf;
        logic nan;
    } fp_flags_t;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rmode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam fp_flags_t   C_FLAGS_NAN  = '{ovrf: 1'b0, udrf: 1'b0, zer: 1'b0, inf: 1'b0, nan: 1'b1};

    function automatic logic rm_is_legal(input logic [2:0] rm);
        return rm <= 3'(RMM);
    endfunction

endpackage : fp_mul_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker: first request at or after ptr.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic           w_found;
    logic [IDW-1:0] w_pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Walk the ring starting at ptr, wrapping past NREQ-1.
            w_pos = IDW'((int'(ptr) + i) % NREQ);
            if (!w_found && req[w_pos]) begin
                grant[w_pos] = 1'b1;
                grant_idx    = w_pos;
                w_found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fp_mul_arbiter
// Brief   : Shares one combinational FP32 multiplier among NREQ requesters.
// Revision: 1.0
// ============================================================================
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_x,
    input  logic [NREQ*32-1:0]  req_y,
    input  logic [NREQ*3-1:0]   req_rm,
    output logic [31:0]         mul_x,
    output logic [31:0]         mul_y,
    output logic [2:0]          mul_rmode,
    input  logic [31:0]         mul_z,
    input  logic [4:0]          mul_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_z,
    output logic [4:0]          rsp_flags,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    arb_state_e      r_state;
    arb_state_e      w_state_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic [31:0]     w_sel_x;
    logic [31:0]     w_sel_y;
    logic [2:0]      w_sel_rm;
    logic [31:0]     r_mul_x;
    logic [31:0]     r_mul_y;
    logic [2:0]      r_mul_rmode;
    logic [31:0]     r_rsp_z;
    logic [4:0]      r_rsp_flags;
    logic [IDW-1:0]  r_rsp_id;

    // Requests are only visible to the arbiter while idle.
    assign w_req = (r_state == IDLE) ? req_valid : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (w_req),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_comb begin
        w_sel_x  = '0;
        w_sel_y  = '0;
        w_sel_rm = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_x  = req_x[32*i +: 32];
                w_sel_y  = req_y[32*i +: 32];
                w_sel_rm = req_rm[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_mul_rmode <= '0;
            r_rsp_z     <= '0;
            r_rsp_flags <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_mul_x     <= w_sel_x;
                        r_mul_y     <= w_sel_y;
                        r_mul_rmode <= w_sel_rm;
                        r_rsp_id    <= w_grant_idx;
                        r_rr_ptr    <= (w_grant_idx == IDW'(NREQ - 1)) ? '0
                                                                        : w_grant_idx + IDW'(1);
                    end
                end
                EXEC: begin
                    // Unsupported rounding modes bypass the multiplier result.
                    if (rm_is_legal(r_mul_rmode)) begin
                        r_rsp_z     <= mul_z;
                        r_rsp_flags <= mul_flags;
                    end else begin
                        r_rsp_z     <= FP32_QNAN;
                        r_rsp_flags <= C_FLAGS_NAN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign mul_rmode = r_mul_rmode;
    assign rsp_valid = (r_state == RESP);
    assign rsp_z     = r_rsp_z;
    assign rsp_flags = r_rsp_flags;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != IDLE);

endmodule : fp_mul_arbiter
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_mul_arbiter
// Brief   : Directed, table-driven bench for fp_mul_arbiter with a stub multiplier.
// Revision: 1.0
// ============================================================================
module tb_fp_mul_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_x;
    logic [NREQ*32-1:0]  req_y;
    logic [NREQ*3-1:0]   req_rm;
    logic [31:0]         mul_x;
    logic [31:0]         mul_y;
    logic [2:0]          mul_rmode;
    logic [31:0]         mul_z;
    logic [4:0]          mul_flags;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_z;
    logic [4:0]          rsp_flags;
    logic [IDW-1:0]      rsp_id;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_rm    (req_rm),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_rmode (mul_rmode),
        .mul_z     (mul_z),
        .mul_flags (mul_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Stub multiplier: true products for the IEEE cases, a scrambling function otherwise.
    always_comb begin
        mul_z     = mul_x ^ mul_y ^ {29'd0, mul_rmode};
        mul_flags = mul_x[4:0] ^ mul_y[9:5];
        if (mul_x == 32'h4040_0000 && mul_y == 32'h4040_0000) begin
            mul_z = 32'h4110_0000; mul_flags = 5'b00000;
        end else if (mul_x == 32'h2000_0000 && mul_y == 32'h1F80_0000) begin
            mul_z = 32'h0040_0000; mul_flags = 5'b00000;
        end else if (mul_x == 32'h0 && mul_y == 32'h0) begin
            mul_z = 32'h0; mul_flags = 5'b00100;
        end
    end

    always @(posedge clk) if (rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [31:0] ez;
        logic [4:0]  ef;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] rm);
        req_x[32*id +: 32] = x;
        req_y[32*id +: 32] = y;
        req_rm[3*id +: 3]  = rm;
    endtask

    // Single op from IDLE with rsp_ready held high; called on a negedge.
    task automatic run_op(input vec_t v);
        set_req(v.id, v.x, v.y, v.rm);
        req_valid       = '0;
        req_valid[v.id] = 1'b1;
        #1;
        check("grant", 32'(req_ready), 32'(1 << v.id));
        tick();
        req_valid = '0;
        #1;
        check("exec_mul_x", mul_x, v.x);
        check("exec_mul_y", mul_y, v.y);
        check("exec_rmode", 32'(mul_rmode), 32'(v.rm));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        tick();
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_z", rsp_z, v.ez);
        check("resp_flags", 32'(rsp_flags), 32'(v.ef));
        check("resp_id", 32'(rsp_id), 32'(v.id));
        tick();
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        vecs[0] = '{0, 32'h4040_0000, 32'h4040_0000, 3'd1, 32'h4110_0000, 5'b00000};
        vecs[1] = '{1, 32'h1234_5678, 32'hAAAA_AAAA, 3'd2, 32'hB89E_FCD0, 5'b01101};
        vecs[2] = '{0, 32'h2000_0000, 32'h1F80_0000, 3'd1, 32'h0040_0000, 5'b00000};
        vecs[3] = '{1, 32'h0000_0000, 32'h0000_0000, 3'd0, 32'h0000_0000, 5'b00100};
        vecs[4] = '{0, 32'hFFFF_0000, 32'h0000_FFFF, 3'd4, 32'hFFFF_FFFB, 5'b11111};
        vecs[5] = '{1, 32'h4040_0000, 32'h4040_0000, 3'd7, 32'h7FC0_0000, 5'b00001};
        vecs[6] = '{0, 32'h1234_5678, 32'hAAAA_AAAA, 3'd5, 32'h7FC0_0000, 5'b00001};

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_rm    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mul_x", mul_x, 32'd0);
        check("rst_rsp_z", rsp_z, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Back-pressure: response held for 10 cycles while another request waits.
        set_req(0, 32'h4040_0000, 32'h4040_0000, 3'd1);
        set_req(1, 32'h1234_5678, 32'hAAAA_AAAA, 3'd2);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_z", rsp_z, 32'h4110_0000);
            check("stall_id", 32'(rsp_id), 32'd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        hs0       = hs_cnt;
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        tick();
        check("release_handshakes", 32'(hs_cnt - hs0), 32'd1);

        // Reset while an op is in EXEC aborts it.
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mul_x", mul_x, 32'd0);
        check("abort_rmode", 32'(mul_rmode), 32'd0);
        check("abort_rsp_z", rsp_z, 32'd0);
        check("abort_rsp_flags", 32'(rsp_flags), 32'd0);
        check("abort_rsp_id", 32'(rsp_id), 32'd0);
        tick();
        check("abort_no_resp", 32'(rsp_valid), 32'd0);

        // Both requesters held: grants alternate starting from 0 after reset.
        req_valid = 2'b11;
        for (int op = 0; op < 4; op++) begin
            #1;
            check("rr_grant", 32'(req_ready), (op % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
            check("rr_rsp_id", 32'(rsp_id), 32'(op % 2));
            check("rr_rsp_z", rsp_z, (op % 2 == 0) ? 32'h4110_0000 : 32'hB89E_FCD0);
            tick();
        end
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fp_mul_arbiter
`default_nettype wire
